// File: rtl/count_ext_pkg.sv
// Shared types and constants for the count extender slice.
// Latency: none (declarations only).
// Backpressure: none.
package count_ext_pkg;

  // Width of the upstream counter's nibble that we extend.
  localparam int CNT_W = 4;

  // Highest nibble value; a step across this boundary is a wrap.
  localparam logic [CNT_W-1:0] NIB_MAX = '1;

  // Tracker state: waiting for a first sample, following the count, or lost.
  typedef enum logic [1:0] {
    UNSYNC = 2'd0,
    TRACK  = 2'd1,
    FAULT  = 2'd2
  } state_t;

  // Per-cycle movement of the upstream count, modulo 16.
  typedef enum logic [1:0] {
    HOLD = 2'd0,
    UP   = 2'd1,
    DN   = 2'd2,
    JUMP = 2'd3
  } delta_t;

  // Map a raw modulo-16 difference onto a movement class.
  function automatic delta_t classify_diff(input logic [CNT_W-1:0] diff);
    delta_t d;
    unique case (diff)
      4'd0:    d = HOLD;
      4'd1:    d = UP;
      4'd15:   d = DN;
      default: d = JUMP;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/count_delta_classify.sv
// Classifies cnt_in - prev (mod 16) as HOLD, UP, DN or JUMP.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs every cycle.
module count_delta_classify
  import count_ext_pkg::*;
(
  input  logic [CNT_W-1:0] prev,
  input  logic [CNT_W-1:0] cnt_in,
  output logic [1:0]       delta
);

  logic [CNT_W-1:0] diff;

  // Modulo-16 subtraction wraps naturally in a 4-bit result.
  always_comb begin
    diff  = cnt_in - prev;
    delta = classify_diff(diff);
  end

endmodule

// File: rtl/count_extender.sv
// Extends a 4-bit up/down/load count with an EXT_W-bit wrap counter.
// Latency: pos and pulses are registered, one cycle after cnt_in.
// Backpressure: none; a new cnt_in sample is consumed every cycle.
module count_extender
  import count_ext_pkg::*;
#(
  parameter int EXT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [CNT_W-1:0]   cnt_in,
  input  logic               load_in,
  output logic [EXT_W+3:0]   pos,
  output logic               wrap_up,
  output logic               wrap_dn,
  output logic               ext_ovf,
  output logic               synced,
  output logic               fault
);

  localparam logic [EXT_W-1:0] EXT_MAX  = '1;
  localparam logic [EXT_W-1:0] EXT_ZERO = '0;
  localparam logic [EXT_W-1:0] EXT_ONE  = {{(EXT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_n;
  logic [CNT_W-1:0] prev_q, prev_n;
  logic [EXT_W-1:0] ext_q, ext_n;
  logic             load_d;
  logic             fault_q, fault_n;
  logic             wrap_up_q, wrap_up_n;
  logic             wrap_dn_q, wrap_dn_n;
  logic             ext_ovf_q, ext_ovf_n;

  logic [1:0]       delta_code;
  delta_t           delta;

  count_delta_classify u_classify (
    .prev   (prev_q),
    .cnt_in (cnt_in),
    .delta  (delta_code)
  );

  assign delta = delta_t'(delta_code);

  // Next-state, extension arithmetic and pulse generation.
  always_comb begin
    state_n   = state_q;
    prev_n    = prev_q;
    ext_n     = ext_q;
    fault_n   = fault_q;
    wrap_up_n = 1'b0;
    wrap_dn_n = 1'b0;
    ext_ovf_n = 1'b0;

    if (load_d) begin
      // A load realigns everything, even if the loaded value looks like a
      // single step from prev, so it is checked before any classification.
      prev_n  = cnt_in;
      ext_n   = EXT_ZERO;
      fault_n = 1'b0;
      state_n = TRACK;
    end else begin
      unique case (state_q)
        UNSYNC: begin
          prev_n  = cnt_in;
          ext_n   = EXT_ZERO;
          state_n = TRACK;
        end
        TRACK: begin
          prev_n = cnt_in;
          unique case (delta)
            UP: begin
              if (prev_q == NIB_MAX) begin
                ext_n     = ext_q + EXT_ONE;
                wrap_up_n = 1'b1;
                ext_ovf_n = (ext_q == EXT_MAX);
              end
            end
            DN: begin
              if (prev_q == '0) begin
                ext_n     = ext_q - EXT_ONE;
                wrap_dn_n = 1'b1;
                ext_ovf_n = (ext_q == EXT_ZERO);
              end
            end
            JUMP: begin
              // Unexplained movement: ext can no longer be trusted, freeze it.
              fault_n = 1'b1;
              state_n = FAULT;
            end
            default: begin
            end
          endcase
        end
        FAULT: begin
          // Keep prev live so a later load sees a consistent nibble.
          prev_n = cnt_in;
        end
        default: begin
          state_n = UNSYNC;
        end
      endcase
    end
  end

  // State and datapath registers; reset overrides any concurrent load.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= UNSYNC;
      prev_q    <= '0;
      ext_q     <= '0;
      load_d    <= 1'b0;
      fault_q   <= 1'b0;
      wrap_up_q <= 1'b0;
      wrap_dn_q <= 1'b0;
      ext_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_n;
      prev_q    <= prev_n;
      ext_q     <= ext_n;
      load_d    <= load_in;
      fault_q   <= fault_n;
      wrap_up_q <= wrap_up_n;
      wrap_dn_q <= wrap_dn_n;
      ext_ovf_q <= ext_ovf_n;
    end
  end

  assign pos     = {ext_q, prev_q};
  assign wrap_up = wrap_up_q;
  assign wrap_dn = wrap_dn_q;
  assign ext_ovf = ext_ovf_q;
  assign synced  = (state_q == TRACK);
  assign fault   = fault_q;

endmodule

// File: tb/tb_count_extender.sv
// Self-checking bench for count_extender with a scoreboard of expected outputs.
// Latency: expectations fall due one clock edge after their stimulus.
// Backpressure: none.
module tb_count_extender;

  localparam int EXT_W = 8;
  localparam int PW    = EXT_W + 4;
  localparam int MAXE  = (1 << EXT_W) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    cnt_in;
  logic          load_in;
  logic [PW-1:0] pos;
  logic          wrap_up, wrap_dn, ext_ovf, synced, fault;

  count_extender #(.EXT_W(EXT_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .cnt_in  (cnt_in),
    .load_in (load_in),
    .pos     (pos),
    .wrap_up (wrap_up),
    .wrap_dn (wrap_dn),
    .ext_ovf (ext_ovf),
    .synced  (synced),
    .fault   (fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            due;
    logic [PW-1:0] pos;
    logic          wu;
    logic          wd;
    logic          ov;
    logic          sy;
    logic          ft;
  } exp_t;

  exp_t sb_q[$];

  int n_vec    = 0;
  int n_err    = 0;
  int edge_cnt = 0;

  // Reference model state (0 = unsync, 1 = track, 2 = fault).
  int m_state = 0;
  int m_prev  = 0;
  int m_ext   = 0;
  bit m_ld    = 1'b0;
  bit m_fault = 1'b0;

  int cur  = 0;
  int n_wu = 0;
  int n_wd = 0;
  int n_ov = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h want=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Advance the reference model by one edge and queue what the DUT should show.
  task automatic push_exp(input logic [3:0] c, input logic l, input logic r);
    exp_t e;
    bit   lw;
    int   d;
    e.wu = 1'b0;
    e.wd = 1'b0;
    e.ov = 1'b0;
    if (r) begin
      m_state = 0; m_prev = 0; m_ext = 0; m_ld = 1'b0; m_fault = 1'b0;
    end else begin
      lw   = m_ld;
      m_ld = l;
      if (lw || m_state == 0) begin
        m_prev = int'(c); m_ext = 0; m_fault = 1'b0; m_state = 1;
      end else if (m_state == 1) begin
        d = (int'(c) - m_prev + 16) % 16;
        if (d == 1 && m_prev == 15) begin
          e.wu = 1'b1; e.ov = (m_ext == MAXE); m_ext = (m_ext + 1) & MAXE;
        end else if (d == 15 && m_prev == 0) begin
          e.wd = 1'b1; e.ov = (m_ext == 0); m_ext = (m_ext + MAXE) & MAXE;
        end else if (d != 0 && d != 1 && d != 15) begin
          m_fault = 1'b1; m_state = 2;
        end
        m_prev = int'(c);
      end else begin
        m_prev = int'(c);
      end
    end
    e.due = edge_cnt + 1;
    e.pos = {m_ext[EXT_W-1:0], m_prev[3:0]};
    e.sy  = (m_state == 1);
    e.ft  = m_fault;
    sb_q.push_back(e);
  endtask

  task automatic drive(input logic [3:0] c, input logic l, input logic r);
    push_exp(c, l, r);
    cnt_in  = c;
    load_in = l;
    reset   = r;
    cur     = int'(c);
    @(posedge clk);
    #2;
    n_wu = n_wu + int'(wrap_up);
    n_wd = n_wd + int'(wrap_dn);
    n_ov = n_ov + int'(ext_ovf);
  endtask

  task automatic step_up(input int n);
    repeat (n) drive(4'((cur + 1) & 15), 1'b0, 1'b0);
  endtask

  task automatic step_dn(input int n);
    repeat (n) drive(4'((cur + 15) & 15), 1'b0, 1'b0);
  endtask

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Pop every expectation that has fallen due and compare it.
  always @(negedge clk) begin : mon
    exp_t e;
    while (sb_q.size() > 0 && sb_q[0].due <= edge_cnt) begin
      e = sb_q.pop_front();
      chk("sb_pos",     32'(pos),  32'(e.pos));
      chk("sb_wrap_up", 32'(wrap_up), 32'(e.wu));
      chk("sb_wrap_dn", 32'(wrap_dn), 32'(e.wd));
      chk("sb_ext_ovf", 32'(ext_ovf), 32'(e.ov));
      chk("sb_synced",  32'(synced),  32'(e.sy));
      chk("sb_fault",   32'(fault),   32'(e.ft));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    reset   = 1'b1;
    cnt_in  = 4'd0;
    load_in = 1'b0;

    drive(4'd0, 1'b0, 1'b1);
    drive(4'd0, 1'b0, 1'b1);
    chk("rst_pos",    32'(pos),    32'h0);
    chk("rst_synced", 32'(synced), 32'h0);
    chk("rst_fault",  32'(fault),  32'h0);

    // Full up-count through one nibble wrap.
    n_wu = 0; n_wd = 0; n_ov = 0;
    drive(4'd0, 1'b0, 1'b0);
    chk("capture_synced", 32'(synced), 32'h1);
    for (int i = 1; i < 16; i++) drive(4'(i), 1'b0, 1'b0);
    drive(4'd0, 1'b0, 1'b0);
    chk("up_wrap_pulse", 32'(wrap_up), 32'h1);
    chk("up_wrap_pos",   32'(pos),     32'h010);
    drive(4'd1, 1'b0, 1'b0);
    chk("up_pos_011",    32'(pos),     32'h011);
    chk("up_wrap_once",  32'(n_wu),    32'h1);

    // Load 2, then count down across zero: ext underflows.
    drive(4'd1, 1'b1, 1'b0);
    drive(4'd2, 1'b0, 1'b0);
    chk("load2_pos", 32'(pos), 32'h002);
    n_wd = 0; n_ov = 0;
    drive(4'd1, 1'b0, 1'b0);
    drive(4'd0, 1'b0, 1'b0);
    drive(4'd15, 1'b0, 1'b0);
    chk("dn_wrap_pulse", 32'(wrap_dn), 32'h1);
    chk("dn_ovf_pulse",  32'(ext_ovf), 32'h1);
    drive(4'd14, 1'b0, 1'b0);
    chk("dn_pos_ffe",    32'(pos),  32'hFFE);
    chk("dn_wrap_once",  32'(n_wd), 32'h1);
    chk("dn_ovf_once",   32'(n_ov), 32'h1);

    // Back up across 0xFFF -> 0x000: ext overflows upward.
    drive(4'd15, 1'b0, 1'b0);
    drive(4'd0, 1'b0, 1'b0);
    chk("upovf_pulse", 32'(ext_ovf), 32'h1);
    chk("upovf_pos",   32'(pos),     32'h000);

    // Load whose value looks like a 15->0 wrap must not wrap.
    step_up(15);
    drive(4'd15, 1'b1, 1'b0);
    drive(4'd0, 1'b0, 1'b0);
    chk("ldwrap_no_pulse", 32'(wrap_up), 32'h0);
    chk("ldwrap_pos",      32'(pos),     32'h000);

    // Climb to 0x035, then load 9.
    step_up(53);
    chk("climb_pos_035", 32'(pos), 32'h035);
    drive(4'd5, 1'b1, 1'b0);
    drive(4'd9, 1'b0, 1'b0);
    chk("load9_pos",    32'(pos),     32'h009);
    chk("load9_nowrap", 32'(wrap_up | wrap_dn), 32'h0);
    chk("load9_synced", 32'(synced),  32'h1);

    // Return to 0x035 and jump 5 -> 11.
    step_up(44);
    chk("reclimb_pos_035", 32'(pos), 32'h035);
    drive(4'd11, 1'b0, 1'b0);
    chk("jump_fault",  32'(fault),  32'h1);
    chk("jump_synced", 32'(synced), 32'h0);
    chk("jump_pos",    32'(pos),    32'h03B);
    n_wu = 0; n_wd = 0;
    step_up(20);
    step_dn(20);
    chk("fault_no_wu",  32'(n_wu),          32'h0);
    chk("fault_no_wd",  32'(n_wd),          32'h0);
    chk("fault_ext_03", 32'(pos[PW-1:4]),   32'h03);
    chk("fault_sticky", 32'(fault),         32'h1);

    // Load 0 clears the fault.
    drive(4'(cur), 1'b1, 1'b0);
    drive(4'd0, 1'b0, 1'b0);
    chk("unfault_fault",  32'(fault),  32'h0);
    chk("unfault_pos",    32'(pos),    32'h000);
    chk("unfault_synced", 32'(synced), 32'h1);

    // Reset in FAULT coinciding with load_in.
    drive(4'd7, 1'b0, 1'b0);
    chk("refault", 32'(fault), 32'h1);
    drive(4'd7, 1'b1, 1'b1);
    chk("rstld_pos",    32'(pos),    32'h0);
    chk("rstld_synced", 32'(synced), 32'h0);
    chk("rstld_fault",  32'(fault),  32'h0);
    chk("rstld_pulses", 32'(wrap_up | wrap_dn | ext_ovf), 32'h0);
    drive(4'd7, 1'b0, 1'b0);
    chk("rstld_track", 32'(synced), 32'h1);
    chk("rstld_pos7",  32'(pos),    32'h007);

    repeat (2) @(posedge clk);
    #2;
    chk("sb_drained", 32'(sb_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/count_extender.md
COUNT_EXTENDER -- requirements
Module: count_extender

Interface
REQ-001 Parameter EXT_W, default 8, meaning the width of the wrap-extension field above the 4-bit count.
REQ-002 clk  input  1  clock; all logic is updated on its rising edge.
REQ-003 reset  input  1  reset; one clock, reset is synchronous and active-high.
REQ-004 cnt_in  input  4  registered count from the upstream up/down/load counter.
REQ-005 load_in  input  1  the same load strobe that drives the upstream counter.
REQ-006 pos  output  EXT_W+4  extended position {ext, low nibble}.
REQ-007 wrap_up  output  1  one-cycle pulse: low nibble wrapped 15->0.
REQ-008 wrap_dn  output  1  one-cycle pulse: low nibble wrapped 0->15.
REQ-009 ext_ovf  output  1  one-cycle pulse: ext itself wrapped, in either direction.
REQ-010 synced  output  1  high while the state is TRACK.
REQ-011 fault  output  1  sticky: an unexplained count jump was seen.

Function
REQ-012 The block SHALL register load_in once (load_d), so that load_d aligns with the cnt_in value that the load produced.
REQ-013 The block SHALL hold prev, the previous cnt_in, and SHALL classify delta = cnt_in - prev (mod 16) as:
- HOLD (0)
- UP (+1)
- DN (15)
- JUMP (any other value).
REQ-014 The FSM states SHALL be UNSYNC, TRACK and FAULT.
REQ-015 In UNSYNC, the next cycle SHALL:
- capture prev = cnt_in and ext = 0
- go to TRACK.
REQ-016 In TRACK, an UP with prev=15 SHALL increment ext and pulse wrap_up, and a DN with prev=0 SHALL decrement ext and pulse wrap_dn.
REQ-017 In TRACK, all other UP, DN and HOLD deltas SHALL leave ext unchanged.
REQ-018 In any state, load_d=1 SHALL take priority over classification, with the following response:
- ext = 0 and prev = cnt_in
- no wrap pulse
- fault cleared
- next state TRACK.
REQ-019 In TRACK, a JUMP with load_d=0 SHALL:
- set fault
- leave ext frozen
- capture prev = cnt_in
- go to FAULT.
REQ-020 In FAULT, prev SHALL keep following cnt_in, ext SHALL stay frozen, and no wrap pulses SHALL be produced.
REQ-021 FAULT SHALL be exited only by reset or load_d.
REQ-022 ext arithmetic SHALL be modulo 2^EXT_W.
REQ-023 ext_ovf SHALL pulse on ext (2^EXT_W-1)->0 and on ext 0->(2^EXT_W-1), in the same cycle as the corresponding wrap pulse.
REQ-024 pos SHALL equal {ext, prev}, registered, giving a latency of exactly 1 cycle from cnt_in.
REQ-025 wrap_up, wrap_dn and ext_ovf SHALL be registered and aligned with the pos update they describe.
REQ-026 A load_d that delivers a value coincidentally equal to prev±1 SHALL still be treated as a load (REQ-018), never as a wrap.

Reset
REQ-027 While reset=1 at a clock edge, the following SHALL hold after that edge:
- state = UNSYNC, prev = 0, ext = 0, load_d = 0
- pos = 0, wrap_up = 0, wrap_dn = 0, ext_ovf = 0
- synced = 0, fault = 0.
REQ-028 A reset asserted mid-operation, including in FAULT or in the same cycle as load_in, SHALL override all other activity.
REQ-029 The first non-reset edge after reset SHALL perform the UNSYNC capture (REQ-015).

Structure
REQ-030 A shared package count_ext_pkg SHALL hold:
- the state enum (UNSYNC, TRACK, FAULT)
- the delta enum (HOLD, UP, DN, JUMP)
- the low-nibble width constant (4).
REQ-031 Delta classification SHALL be a single combinational sub-module, count_delta_classify (inputs prev, cnt_in; output delta code).
REQ-032 count_extender SHALL contain only the FSM, the registers and the output logic.

Verification
REQ-033 Release reset, then drive cnt_in 0,1,…,15,0,1 -> exactly one wrap_up, on the cycle after 15->0, and pos=0x011 one cycle after the final 1 is applied.
REQ-034 Drive cnt_in 2,1,0,15,14 from pos=0x002 -> one wrap_dn, then pos=0xFFE (EXT_W=8) together with an ext_ovf pulse on the wrap cycle.
REQ-035 While tracking at pos=0x035, present cnt_in=9 with load_d=1 -> pos=0x009, no wrap pulse, synced stays 1.
REQ-036 From pos=0x035, jump cnt_in 5->11 with no load -> fault=1 and synced=0, pos ext frozen at 0x03, no further wraps while cnt_in cycles.
REQ-037 Continuing REQ-036, assert load with data 0 -> fault clears, pos=0x000, synced=1.
REQ-038 Assert reset while in FAULT with load_in=1 in the same cycle -> all outputs 0, state UNSYNC, then TRACK on the next edge.
